// File: rtl/sap_loader_pkg.sv
// Shared constants and helpers for the SAP front-panel loader.
// Inc/dec FSM state encoding plus select and repeat-counter width helpers.
package sap_loader_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter only ever holds values up to max(delay, rate) - 1.
  function automatic int cnt_w(input int d, input int r);
    int m;
    m = (d > r) ? d : r;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sap_press_detect.sv
// Press edge detector for one debounced active-low button.
// Ports: clk, reset, btn_n_i (0 = pressed), press_o (new press), held_o.
module sap_press_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o,
  output logic held_o
);

  // History resets to "pressed" so a button held through
  // reset must be released before it can register a press.
  logic hist_q;

  always_ff @(posedge clk) begin
    if (reset) hist_q <= 1'b0;
    else       hist_q <= btn_n_i;
  end

  assign held_o  = ~btn_n_i;
  assign press_o = ~btn_n_i & hist_q;

endmodule

// File: rtl/sap_manual_loader.sv
// Front-panel entry value, register select and one-shot bus load.
// Ports: clk, reset, btn_inc_n/btn_sel_n/btn_load_n (active low),
//   btn_dec_n when SAP_LOADER_DEC_EN is defined;
//   value, sel, bus_data, bus_oe, load (one-hot strobe).
module sap_manual_loader
  import sap_loader_pkg::*;
#(
  parameter  int WIDTH        = 8,
  parameter  int NUM_REGS     = 2,
  parameter  int REPEAT_DELAY = 12000000,
  parameter  int REPEAT_RATE  = 3000000,
  localparam int SEL_W        = sel_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_inc_n,
`ifdef SAP_LOADER_DEC_EN
  input  logic                btn_dec_n,
`endif
  input  logic                btn_sel_n,
  input  logic                btn_load_n,
  output logic [WIDTH-1:0]    value,
  output logic [SEL_W-1:0]    sel,
  output logic [WIDTH-1:0]    bus_data,
  output logic                bus_oe,
  output logic [NUM_REGS-1:0] load
);

  localparam int CW = cnt_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REGS - 1);

  logic inc_press, inc_held;
  logic sel_press, sel_held_unused;
  logic ld_press, ld_held_unused;

  sap_press_detect u_inc (
    .clk(clk), .reset(reset), .btn_n_i(btn_inc_n),
    .press_o(inc_press), .held_o(inc_held)
  );
  sap_press_detect u_sel (
    .clk(clk), .reset(reset), .btn_n_i(btn_sel_n),
    .press_o(sel_press), .held_o(sel_held_unused)
  );
  sap_press_detect u_load (
    .clk(clk), .reset(reset), .btn_n_i(btn_load_n),
    .press_o(ld_press), .held_o(ld_held_unused)
  );

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    value_q, value_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                oe_q;
  logic [NUM_REGS-1:0] ld_q, ld_d;
  logic [WIDTH-1:0]    data_q;
  logic                step;
  logic                run_held;

`ifdef SAP_LOADER_DEC_EN
  logic dec_press, dec_held;
  logic dir_q, dir_d;
  logic up;

  sap_press_detect u_dec (
    .clk(clk), .reset(reset), .btn_n_i(btn_dec_n),
    .press_o(dec_press), .held_o(dec_held)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
`ifdef SAP_LOADER_DEC_EN
    dir_d    = dir_q;
    up       = dir_q;
    run_held = dir_q ? inc_held : dec_held;
`else
    run_held = inc_held;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef SAP_LOADER_DEC_EN
        if (inc_press && !dec_held) begin
          step    = 1'b1;
          up      = 1'b1;
          dir_d   = 1'b1;
          state_d = ST_HOLD;
        end else if (dec_press && !inc_held) begin
          step    = 1'b1;
          up      = 1'b0;
          dir_d   = 1'b0;
          state_d = ST_HOLD;
        end
`else
        if (inc_press) begin
          step    = 1'b1;
          state_d = ST_HOLD;
        end
`endif
      end
      ST_HOLD: begin
        if (!run_held) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!run_held) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RATE_LAST) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef SAP_LOADER_DEC_EN
    // Both buttons down: park in IDLE until a fresh single press.
    if (inc_held && dec_held) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      step    = 1'b0;
      dir_d   = dir_q;
    end
`endif
  end

  always_comb begin
    value_d = value_q;
`ifdef SAP_LOADER_DEC_EN
    if (step) value_d = up ? value_q + 1'b1 : value_q - 1'b1;
`else
    if (step) value_d = value_q + 1'b1;
`endif
  end

  always_comb begin
    sel_d = sel_q;
    if (sel_press) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
  end

  // Strobe targets the pre-update select value.
  always_comb begin
    ld_d = '0;
    if (ld_press) ld_d[sel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      value_q <= '0;
      sel_q   <= '0;
      oe_q    <= 1'b0;
      ld_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      sel_q   <= sel_d;
      oe_q    <= ld_press;
      ld_q    <= ld_d;
      data_q  <= ld_press ? value_q : '0;
    end
  end

`ifdef SAP_LOADER_DEC_EN
  always_ff @(posedge clk) begin
    if (reset) dir_q <= 1'b1;
    else       dir_q <= dir_d;
  end
`endif

  assign value    = value_q;
  assign sel      = sel_q;
  assign bus_oe   = oe_q;
  assign load     = ld_q;
  assign bus_data = data_q;

endmodule

// File: tb/tb_sap_manual_loader.sv
// Scoreboard bench for sap_manual_loader.
// Define SAP_LOADER_DEC_EN to also exercise decrement.
module tb_sap_manual_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_inc_n = 1'b1;
  logic       btn_sel_n = 1'b1;
  logic       btn_load_n = 1'b1;
`ifdef SAP_LOADER_DEC_EN
  logic       btn_dec_n = 1'b1;
`endif
  logic [7:0] value;
  logic [1:0] sel;
  logic [7:0] bus_data;
  logic       bus_oe;
  logic [2:0] load;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] ld;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  sap_manual_loader #(
    .WIDTH(8), .NUM_REGS(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_inc_n(btn_inc_n),
`ifdef SAP_LOADER_DEC_EN
    .btn_dec_n(btn_dec_n),
`endif
    .btn_sel_n(btn_sel_n),
    .btn_load_n(btn_load_n),
    .value(value),
    .sel(sel),
    .bus_data(bus_data),
    .bus_oe(bus_oe),
    .load(load)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe must match the next queued expectation,
  // and outside strobes the bus must be quiet.
  always @(negedge clk) begin
    exp_t e;
    tests++;
    if (bus_oe === 1'b1) begin
      if (q.size() == 0) begin
        fails++;
        $display("FAIL spurious_load: load=%b data=%h, required no strobe",
                 load, bus_data);
      end else begin
        e = q.pop_front();
        if (load !== e.ld || bus_data !== e.data) begin
          fails++;
          $display("FAIL load_strobe: load=%b data=%h, required load=%b data=%h",
                   load, bus_data, e.ld, e.data);
        end
      end
    end else if (bus_oe !== 1'b0 || load !== 3'b000 || bus_data !== 8'h00) begin
      fails++;
      $display("FAIL idle_bus: oe=%b load=%b data=%h, required 0/000/00",
               bus_oe, load, bus_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic tap_inc();
    btn_inc_n = 1'b0;
    tick(1);
    btn_inc_n = 1'b1;
    tick(1);
  endtask

  task automatic tap_sel();
    btn_sel_n = 1'b0;
    tick(1);
    btn_sel_n = 1'b1;
    tick(1);
  endtask

`ifdef SAP_LOADER_DEC_EN
  task automatic tap_dec();
    btn_dec_n = 1'b0;
    tick(1);
    btn_dec_n = 1'b1;
    tick(1);
  endtask
`endif

  int hold_exp[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};

  initial begin
    // Reset state
    do_reset();
    chk("rst_value", value, 0);
    chk("rst_sel", sel, 0);
    chk("rst_oe", bus_oe, 0);
    chk("rst_load", load, 0);
    chk("rst_data", bus_data, 0);

    // 1: single taps
    for (int i = 0; i < 3; i++) tap_inc();
    chk("tap3_value", value, 3);

    // 2: hold inc 12 cycles
    do_reset();
    btn_inc_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk($sformatf("hold_p%0d", k + 1), value, hold_exp[k]);
    end
    btn_inc_n = 1'b1;
    tick(3);
    chk("hold_release", value, 5);
    tap_inc();
    chk("hold_rearm", value, 6);

    // 3: wrap and select
    do_reset();
    for (int i = 0; i < 254; i++) tap_inc();
    chk("pre_wrap", value, 8'hFE);
    tap_inc();
    chk("wrap_ff", value, 8'hFF);
    tap_inc();
    chk("wrap_00", value, 8'h00);
    tap_sel();
    chk("sel_1", sel, 1);
    tap_sel();
    chk("sel_2", sel, 2);
    tap_sel();
    chk("sel_0", sel, 0);

    // 4: held load gives one strobe
    do_reset();
    for (int i = 0; i < 42; i++) tap_inc();
    tap_sel();
    tap_sel();
    chk("ld_value", value, 8'h2A);
    chk("ld_sel", sel, 2);
    q.push_back('{ld: 3'b100, data: 8'h2A});
    btn_load_n = 1'b0;
    tick(10);
    btn_load_n = 1'b1;
    tick(3);

    // 5: inc+sel+load together
    do_reset();
    for (int i = 0; i < 7; i++) tap_inc();
    q.push_back('{ld: 3'b001, data: 8'h07});
    btn_inc_n  = 1'b0;
    btn_sel_n  = 1'b0;
    btn_load_n = 1'b0;
    tick(1);
    btn_inc_n  = 1'b1;
    btn_sel_n  = 1'b1;
    btn_load_n = 1'b1;
    tick(3);
    chk("simul_value", value, 8);
    chk("simul_sel", sel, 1);

    // 6: reset while auto-repeating
    do_reset();
    btn_inc_n = 1'b0;
    tick(8);
    chk("rep_pre_reset", value, 3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rep_reset", value, 0);
    tick(6);
    chk("held_through_reset", value, 0);
    btn_inc_n = 1'b1;
    tick(2);
    chk("after_release", value, 0);
    tap_inc();
    chk("after_repress", value, 1);

    // Load pressed during reset is dropped and ignored while held
    btn_load_n = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    btn_load_n = 1'b1;
    tick(3);

`ifdef SAP_LOADER_DEC_EN
    do_reset();
    tap_dec();
    chk("dec_wrap", value, 8'hFF);
    btn_inc_n = 1'b0;
    btn_dec_n = 1'b0;
    tick(8);
    chk("incdec_held", value, 8'hFF);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    tick(2);
    chk("incdec_release", value, 8'hFF);
    tap_dec();
    chk("dec_rearm", value, 8'hFE);
`endif

    tick(3);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_loads: %0d strobes missing, required 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
